// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data responder.
// The read FSM encoding and the latency counter width live here.
package dmem_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int LANES      = 8;
    localparam int CNT_WIDTH  = 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } rd_state_t;

    // Counter preload for a read of the given latency (1..4 maps to 0..3).
    function automatic logic [CNT_WIDTH-1:0] latency_preload(input int latency);
        return CNT_WIDTH'(latency - 1);
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// One byte lane of the data SRAM window: single-port, synchronous write,
// registered read that holds its output until the next read enable.
module dmem_bank #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata
);

    logic [7:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data port responder: window decode, byte-lane SRAM banks,
// read-latency FSM with pipeline stall, and registered fault pulse.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 12,
    parameter logic [63:0] BASE_ADDR    = 64'h0000_0000_0000_0000,
    parameter int          READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  data_read_in,
    input  logic                  data_write_in,
    input  logic [DATA_WIDTH-1:0] data_address_in,
    input  logic [LANES-1:0]      data_write_mask_in,
    input  logic [DATA_WIDTH-1:0] data_write_value_in,
    output logic [DATA_WIDTH-1:0] data_read_value_out,
    output logic                  stall_out,
    output logic                  fault_out
);

    rd_state_t             state;
    rd_state_t             state_nxt;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [CNT_WIDTH-1:0]  cnt_nxt;
    logic                  capture;

    logic [DATA_WIDTH-1:0] offset;
    logic                  in_window;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  is_idle;
    logic                  rd_issue;
    logic                  wr_commit;
    logic                  oow_read;
    logic                  fault_set;

    logic [DATA_WIDTH-1:0] bank_word;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  fault_q;
    logic                  unused_low_bits;

    // Subtracting the base lets addresses below BASE_ADDR wrap to a huge
    // offset, so a single upper-bits test rejects both sides of the window.
    assign offset          = data_address_in - BASE_ADDR;
    assign in_window       = (offset[DATA_WIDTH-1:ADDR_WIDTH+3] == '0);
    assign word_idx        = offset[ADDR_WIDTH+2:3];
    assign unused_low_bits = ^offset[2:0];

    assign is_idle   = (state == IDLE);
    assign rd_issue  = is_idle & data_read_in & ~data_write_in & in_window;
    assign wr_commit = is_idle & data_write_in & ~data_read_in & in_window;
    assign oow_read  = is_idle & data_read_in & ~data_write_in & ~in_window;
    assign fault_set = is_idle & ((data_read_in & data_write_in)
                     | ((data_read_in | data_write_in) & ~in_window));

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        dmem_bank #(
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_bank (
            .clk   (clk),
            .we    (wr_commit & data_write_mask_in[i]),
            .re    (rd_issue),
            .addr  (word_idx),
            .wdata (data_write_value_in[8*i +: 8]),
            .rdata (bank_word[8*i +: 8])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (rd_issue) begin
                    if (READ_LATENCY == 1) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = latency_preload(READ_LATENCY);
                    end
                end
            end
            WAIT: begin
                // Counter reaches zero on this edge: latch the word now.
                cnt_nxt = cnt - 1'b1;
                if (cnt == CNT_WIDTH'(1)) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Leaving DONE re-latches the bank word so single-cycle reads stay
    // visible once the FSM is back in IDLE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_set;
            if (oow_read) begin
                rdata_q <= '0;
            end else if (capture || state == DONE) begin
                rdata_q <= bank_word;
            end
        end
    end

    assign data_read_value_out = (state == DONE) ? bank_word : rdata_q;
    assign stall_out = reset_n & data_read_in & ~data_write_in & in_window
                     & (state != DONE);
    assign fault_out = fault_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (latency 1 and 3) driven from a
// word-array reference model with directed and randomized traffic.
module tb_dmem_responder;

    localparam int          AW   = 6;
    localparam logic [63:0] BASE = 64'h0000_0000_0000_1000;
    localparam logic [63:0] WIN  = 64'h200;
    localparam int          LAT0 = 1;
    localparam int          LAT1 = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rd    [2];
    logic        wr    [2];
    logic [63:0] addr  [2];
    logic [7:0]  mask  [2];
    logic [63:0] wval  [2];
    logic [63:0] rval  [2];
    logic        stall [2];
    logic        fault [2];

    logic [63:0] mdl        [2][64];
    logic [63:0] last_data  [2];
    bit          pend_fault [2];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .READ_LATENCY(LAT0)) u_dut0 (
        .clk                 (clk),
        .reset_n             (reset_n),
        .data_read_in        (rd[0]),
        .data_write_in       (wr[0]),
        .data_address_in     (addr[0]),
        .data_write_mask_in  (mask[0]),
        .data_write_value_in (wval[0]),
        .data_read_value_out (rval[0]),
        .stall_out           (stall[0]),
        .fault_out           (fault[0])
    );

    dmem_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .READ_LATENCY(LAT1)) u_dut1 (
        .clk                 (clk),
        .reset_n             (reset_n),
        .data_read_in        (rd[1]),
        .data_write_in       (wr[1]),
        .data_address_in     (addr[1]),
        .data_write_mask_in  (mask[1]),
        .data_write_value_in (wval[1]),
        .data_read_value_out (rval[1]),
        .stall_out           (stall[1]),
        .fault_out           (fault[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [63:0] rand_in_addr();
        return BASE + (64'($urandom_range(0, 63)) << 3) + 64'($urandom_range(0, 7));
    endfunction

    // Silence the instance not being exercised; a fault it raises now is not tracked.
    task automatic park_other(input int d);
        rd[1-d] = 1'b0;
        wr[1-d] = 1'b0;
        pend_fault[1-d] = 1'b0;
    endtask

    task automatic op_write(input int d, input logic [63:0] a, input logic [63:0] v,
                            input logic [7:0] m);
        logic [63:0] off;
        @(negedge clk);
        park_other(d);
        rd[d] = 1'b0; wr[d] = 1'b1; addr[d] = a; wval[d] = v; mask[d] = m;
        #1;
        total++;
        if (fault[d] !== pend_fault[d]) begin
            bad++; $display("FAIL wr_fault d=%0d got=%b want=%b", d, fault[d], pend_fault[d]);
        end
        total++;
        if (stall[d] !== 1'b0) begin
            bad++; $display("FAIL wr_stall d=%0d got=%b want=0", d, stall[d]);
        end
        off = a - BASE;
        if (off < WIN) begin
            for (int i = 0; i < 8; i++)
                if (m[i]) mdl[d][off[8:3]][8*i +: 8] = v[8*i +: 8];
            pend_fault[d] = 1'b0;
        end else begin
            pend_fault[d] = 1'b1;
        end
    endtask

    task automatic op_read(input int d, input logic [63:0] a);
        logic [63:0] off;
        logic [63:0] exp_v;
        int cycles;
        @(negedge clk);
        park_other(d);
        rd[d] = 1'b1; wr[d] = 1'b0; addr[d] = a;
        #1;
        total++;
        if (fault[d] !== pend_fault[d]) begin
            bad++; $display("FAIL rd_fault d=%0d got=%b want=%b", d, fault[d], pend_fault[d]);
        end
        off = a - BASE;
        if (off >= WIN) begin
            total++;
            if (stall[d] !== 1'b0) begin
                bad++; $display("FAIL oow_stall d=%0d got=%b want=0", d, stall[d]);
            end
            pend_fault[d] = 1'b1;
            last_data[d]  = 64'h0;
        end else begin
            exp_v  = mdl[d][off[8:3]];
            cycles = 0;
            while (stall[d] === 1'b1 && cycles < 8) begin
                cycles++;
                @(negedge clk);
                #1;
            end
            total++;
            if (cycles != lat_of(d)) begin
                bad++; $display("FAIL rd_stall_cycles d=%0d got=%0d want=%0d", d, cycles, lat_of(d));
            end
            total++;
            if (rval[d] !== exp_v) begin
                bad++; $display("FAIL rd_data d=%0d addr=%h got=%h want=%h", d, a, rval[d], exp_v);
            end
            pend_fault[d] = 1'b0;
            last_data[d]  = exp_v;
        end
    endtask

    task automatic op_illegal(input int d, input logic [63:0] a, input logic [63:0] v);
        @(negedge clk);
        park_other(d);
        rd[d] = 1'b1; wr[d] = 1'b1; addr[d] = a; wval[d] = v; mask[d] = 8'hFF;
        #1;
        total++;
        if (fault[d] !== pend_fault[d]) begin
            bad++; $display("FAIL ill_fault_prev d=%0d got=%b want=%b", d, fault[d], pend_fault[d]);
        end
        total++;
        if (stall[d] !== 1'b0) begin
            bad++; $display("FAIL ill_stall d=%0d got=%b want=0", d, stall[d]);
        end
        pend_fault[d] = 1'b1;
    endtask

    task automatic op_idle(input int d);
        @(negedge clk);
        park_other(d);
        rd[d] = 1'b0; wr[d] = 1'b0;
        #1;
        total++;
        if (fault[d] !== pend_fault[d]) begin
            bad++; $display("FAIL idle_fault d=%0d got=%b want=%b", d, fault[d], pend_fault[d]);
        end
        total++;
        if (rval[d] !== last_data[d]) begin
            bad++; $display("FAIL idle_data d=%0d got=%h want=%h", d, rval[d], last_data[d]);
        end
        pend_fault[d] = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rd[d] = 1'b1; wr[d] = 1'b0; addr[d] = BASE; mask[d] = 8'h00; wval[d] = 64'h0;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (stall[d] !== 1'b0) begin
                bad++; $display("FAIL reset_stall d=%0d got=%b want=0", d, stall[d]);
            end
            total++;
            if (fault[d] !== 1'b0) begin
                bad++; $display("FAIL reset_fault d=%0d got=%b want=0", d, fault[d]);
            end
            total++;
            if (rval[d] !== 64'h0) begin
                bad++; $display("FAIL reset_data d=%0d got=%h want=0", d, rval[d]);
            end
            rd[d] = 1'b0;
            pend_fault[d] = 1'b0;
            last_data[d]  = 64'h0;
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 64; w++)
                op_write(d, BASE + 64'(w * 8), rand64(), 8'hFF);
        op_idle(1);
    endtask

    task automatic test_spec_vectors();
        op_write(0, BASE + 64'h10, 64'h1122_3344_5566_7788, 8'hFF);
        op_read(0, BASE + 64'h10);
        total++;
        if (rval[0] !== 64'h1122_3344_5566_7788) begin
            bad++; $display("FAIL vec_full got=%h want=1122334455667788", rval[0]);
        end
        op_idle(0);
        op_write(0, BASE + 64'h18, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        op_write(0, BASE + 64'h18, 64'hAAAA_0000_0000_00BB, 8'hC1);
        op_read(0, BASE + 64'h18);
        total++;
        if (rval[0] !== 64'hAAAA_FFFF_FFFF_FFBB) begin
            bad++; $display("FAIL vec_mask got=%h want=aaaaffffffffffbb", rval[0]);
        end
        op_idle(0);
        op_write(1, BASE + 64'h10, 64'h0123_4567_89AB_CDEF, 8'hFF);
        op_write(1, BASE + 64'h10, rand64(), 8'h00);
        op_read(1, BASE + 64'h10);
        op_idle(1);
    endtask

    task automatic test_window();
        for (int d = 0; d < 2; d++) begin
            op_read(d, BASE + WIN);
            op_idle(d);
            op_read(d, BASE - 64'h8);
            op_idle(d);
            op_write(d, BASE + WIN, rand64(), 8'hFF);
            op_idle(d);
            op_read(d, BASE);
            op_read(d, BASE + WIN - 64'h8);
            op_idle(d);
        end
    endtask

    task automatic test_illegal();
        for (int d = 0; d < 2; d++) begin
            op_illegal(d, BASE + 64'h20, 64'h0);
            op_idle(d);
            op_read(d, BASE + 64'h20);
            op_idle(d);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a;
        for (int d = 0; d < 2; d++) begin
            a = rand_in_addr();
            op_write(d, a, rand64(), 8'($urandom));
            op_read(d, a);
            op_read(d, rand_in_addr());
            op_read(d, rand_in_addr());
            op_idle(d);
            op_idle(d);
        end
    endtask

    task automatic test_random();
        int d;
        int kind;
        for (int n = 0; n < 120; n++) begin
            d    = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 10));
            if (kind <= 3)      op_read(d, rand_in_addr());
            else if (kind <= 6) op_write(d, rand_in_addr(), rand64(), 8'($urandom));
            else if (kind == 7) op_read(d, BASE + WIN + (64'($urandom_range(0, 255)) << 3));
            else if (kind == 8) op_write(d, BASE - 64'h8 * 64'($urandom_range(1, 64)), rand64(), 8'hFF);
            else if (kind == 9) op_illegal(d, rand_in_addr(), rand64());
            else                op_idle(d);
        end
        op_idle(0);
        op_idle(1);
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        rd[0] = 1'b0; wr[0] = 1'b0;
        rd[1] = 1'b1; wr[1] = 1'b0; addr[1] = BASE + 64'h40;
        #1;
        total++;
        if (stall[1] !== 1'b1) begin
            bad++; $display("FAIL mid_issue_stall got=%b want=1", stall[1]);
        end
        @(negedge clk);
        #1;
        total++;
        if (stall[1] !== 1'b1) begin
            bad++; $display("FAIL mid_wait_stall got=%b want=1", stall[1]);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (stall[1] !== 1'b0) begin
            bad++; $display("FAIL mid_reset_stall got=%b want=0", stall[1]);
        end
        @(negedge clk);
        rd[1] = 1'b0;
        reset_n = 1'b1;
        #1;
        total++;
        if (stall[1] !== 1'b0) begin
            bad++; $display("FAIL mid_after_stall got=%b want=0", stall[1]);
        end
        total++;
        if (rval[1] !== 64'h0) begin
            bad++; $display("FAIL mid_after_data got=%h want=0", rval[1]);
        end
        for (int d = 0; d < 2; d++) begin
            pend_fault[d] = 1'b0;
            last_data[d]  = 64'h0;
        end
        op_idle(1);
        op_read(1, BASE + 64'h40);
        op_idle(1);
    endtask

    initial begin
        reset_n = 1'b0;
        test_reset();
        test_fill();
        test_spec_vectors();
        test_window();
        test_illegal();
        test_back_to_back();
        test_random();
        test_reset_mid_read();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
